// File: rtl/vs_inhibit_pkg.sv
// ============================================================================
// Module      : vs_inhibit_pkg
// Description : Shared state encoding and saturation helper for inhibit_release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vs_inhibit_pkg;

    typedef enum logic [1:0] {
        IR_PASS  = 2'd0,
        IR_HOLD  = 2'd1,
        IR_DRAIN = 2'd2
    } ir_state_t;

    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_updown_counter.sv
// ============================================================================
// Module      : sat_updown_counter
// Description : Up/down counter that sticks at 0 and at its maximum, flagging
//               an increment lost at saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_updown_counter
    import vs_inhibit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             sat_drop
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(sat_max(WIDTH));

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Simultaneous inc and dec cancel, so a full counter never drops in that case.
    always_comb begin
        count_d  = count_q;
        sat_drop = 1'b0;
        if (inc && !dec) begin
            if (count_q == C_MAX) begin
                sat_drop = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/inhibit_release.sv
// ============================================================================
// Module      : inhibit_release
// Description : Holds event pulses while enable_l is high and replays them one
//               per cycle once released. Optional released_cnt output when
//               VS_INHIBIT_RELEASE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inhibit_release
    import vs_inhibit_pkg::*;
#(
    parameter int CNT_WIDTH    = 4,
    parameter int PASS_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 enable_l,
    output logic                 out,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 busy,
    output logic                 overflow
`ifdef VS_INHIBIT_RELEASE_STATS_EN
    ,
    output logic [15:0]          released_cnt
`endif
);

    if (PASS_LATENCY != 1) begin : g_latency_check
        $error("inhibit_release: PASS_LATENCY must be 1");
    end

    ir_state_t mode;
    ir_state_t state_d;
    ir_state_t state_q;
    logic      out_d;
    logic      out_q;
    logic      overflow_d;
    logic      overflow_q;
    logic      cnt_inc;
    logic      cnt_dec;
    logic      sat_drop;

    sat_updown_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_pending (
        .clk      (clk),
        .reset    (reset),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (pending),
        .sat_drop (sat_drop)
    );

    assign busy = (pending != '0);

    // The action of a cycle follows the live enable_l, so re-inhibit stops
    // draining at the very next edge.
    always_comb begin
        mode = IR_PASS;
        if (enable_l) begin
            mode = IR_HOLD;
        end else if (busy) begin
            mode = IR_DRAIN;
        end
        out_d      = (mode == IR_DRAIN) || ((mode == IR_PASS) && in);
        cnt_inc    = in && (mode != IR_PASS);
        cnt_dec    = (mode == IR_DRAIN);
        overflow_d = overflow_q || sat_drop;
        if (enable_l) begin
            state_d = IR_HOLD;
        end else if ((mode == IR_DRAIN) && ((pending > CNT_WIDTH'(1)) || in)) begin
            state_d = IR_DRAIN;
        end else begin
            state_d = IR_PASS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IR_PASS;
            out_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
            assert ((state_q != IR_PASS) || (pending == '0));
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;

`ifdef VS_INHIBIT_RELEASE_STATS_EN
    logic [15:0] released_cnt_d;
    logic [15:0] released_cnt_q;

    always_comb begin
        released_cnt_d = released_cnt_q + {15'd0, cnt_dec};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            released_cnt_q <= 16'd0;
        end else begin
            released_cnt_q <= released_cnt_d;
        end
    end

    assign released_cnt = released_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inhibit_release.sv
// ============================================================================
// Module      : tb_inhibit_release
// Description : Scoreboard bench for inhibit_release (CNT_WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inhibit_release;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_s;
    logic       en_s;
    logic       out_w;
    logic [3:0] pending_w;
    logic       busy_w;
    logic       ovf_w;
`ifdef VS_INHIBIT_RELEASE_STATS_EN
    logic [15:0] rel_w;
`endif

    always #5 clk = ~clk;

    inhibit_release #(
        .CNT_WIDTH    (4),
        .PASS_LATENCY (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_s),
        .enable_l (en_s),
        .out      (out_w),
        .pending  (pending_w),
        .busy     (busy_w),
        .overflow (ovf_w)
`ifdef VS_INHIBIT_RELEASE_STATS_EN
        ,
        .released_cnt (rel_w)
`endif
    );

    typedef struct {
        logic       o;
        logic [3:0] p;
        logic       ov;
        logic       b;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         out_cnt = 0;
    logic [3:0] mp  = 4'd0;
    logic       mov = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model computes the post-edge result before the edge happens.
    task automatic step(input logic r, input logic i, input logic e);
        exp_t x;
        if (r) begin
            mp  = 4'd0;
            mov = 1'b0;
            x.o = 1'b0;
        end else if (e) begin
            x.o = 1'b0;
            if (i) begin
                if (mp == 4'hF) mov = 1'b1;
                else mp = mp + 4'd1;
            end
        end else if (mp != 4'd0) begin
            x.o = 1'b1;
            if (!i) mp = mp - 4'd1;
        end else begin
            x.o = i;
        end
        x.p  = mp;
        x.ov = mov;
        x.b  = (mp != 4'd0);
        sb.push_back(x);
        reset = r;
        in_s  = i;
        en_s  = e;
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("out",      {31'd0, out_w},  {31'd0, x.o});
        check("pending",  {28'd0, pending_w}, {28'd0, x.p});
        check("overflow", {31'd0, ovf_w},  {31'd0, x.ov});
        check("busy",     {31'd0, busy_w}, {31'd0, x.b});
        if (out_w) out_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        in_s  = 1'b0;
        en_s  = 1'b0;

        step(1, 0, 0);
        step(1, 0, 0);
        check("rst_out",     {31'd0, out_w}, 0);
        check("rst_pending", {28'd0, pending_w}, 0);
        check("rst_overflow", {31'd0, ovf_w}, 0);
        check("rst_busy",    {31'd0, busy_w}, 0);

        // PASS: pulses echo one cycle later
        step(0, 0, 0);
        step(0, 1, 0);
        check("pass_out_hi", {31'd0, out_w}, 1);
        step(0, 0, 0);
        check("pass_out_lo", {31'd0, out_w}, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        check("pass_out_hi2", {31'd0, out_w}, 1);
        step(0, 0, 0);

        // Hold three, then release
        for (int k = 0; k < 3; k++) step(0, 1, 1);
        check("hold_pending", {28'd0, pending_w}, 3);
        check("hold_out", {31'd0, out_w}, 0);
        out_cnt = 0;
        for (int k = 0; k < 5; k++) step(0, 0, 0);
        check("release_count", out_cnt, 3);
        check("release_pending", {28'd0, pending_w}, 0);

        // Concurrent in on first drain cycle
        step(0, 1, 1);
        step(0, 1, 1);
        out_cnt = 0;
        step(0, 1, 0);
        check("conc_pending", {28'd0, pending_w}, 2);
        for (int k = 0; k < 4; k++) step(0, 0, 0);
        check("conc_count", out_cnt, 3);
        step(0, 1, 0);
        check("conc_follow", {31'd0, out_w}, 1);
        step(0, 0, 0);

        // Saturation
        for (int k = 0; k < 17; k++) step(0, 1, 1);
        check("sat_pending", {28'd0, pending_w}, 15);
        check("sat_overflow", {31'd0, ovf_w}, 1);
        out_cnt = 0;
        for (int k = 0; k < 18; k++) step(0, 0, 0);
        check("sat_count", out_cnt, 15);
        check("sat_overflow_sticky", {31'd0, ovf_w}, 1);

        // Re-inhibit then reset mid-drain
        step(1, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        check("reinh_pending", {28'd0, pending_w}, 3);
        check("reinh_out", {31'd0, out_w}, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("middrain_rst_pending", {28'd0, pending_w}, 0);
        check("middrain_rst_out", {31'd0, out_w}, 0);
        check("middrain_rst_overflow", {31'd0, ovf_w}, 0);

`ifdef VS_INHIBIT_RELEASE_STATS_EN
        step(1, 0, 0);
        check("stats_rst", {16'd0, rel_w}, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0);
        check("stats_drain", {16'd0, rel_w}, 4);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("stats_pass", {16'd0, rel_w}, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
